vram_arbiter: RTL and testbench

Single-port video RAM arbiter between the video controller's character fetch port and the CPU bus. It sits directly upstream of the video controller: it supplies the controller's `addr`/`rd`/`din` port with fixed one-cycle read latency and absolute priority. Remaining RAM slots go to the CPU through a req/ack handshake. A one-entry posted write buffer with read forwarding keeps CPU writes from stalling behind video fetches.

---
 rtl/vram_arbiter_pkg.sv | 20 ++
 rtl/vram_wbuf.sv | 58 +++++
 rtl/vram_arbiter.sv | 148 ++++++++++++++
 tb/tb_vram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the video RAM arbiter: default bus widths and FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vram_arbiter_pkg;

   // Default RAM geometry: 64 KiB byte-wide video RAM.
   localparam int VRAM_ADDR_W = 16;
   localparam int VRAM_DATA_W = 8;

   // CPU-side access sequencer states.
   //   IDLE    : waiting for (or holding off) a CPU request
   //   S_RDATA : CPU read address presented last cycle, RAM data arrives now
   //   S_ACK   : one-cycle completion pulse, request line ignored
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      S_RDATA = 2'd1,
      S_ACK   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/vram_wbuf.sv
// One-entry posted write buffer: holds a CPU write until a free RAM slot drains it.
// Latency: load visible on outputs the cycle after load_i; hit_o is combinational.
// Backpressure: none internally; the owner must not load while full unless draining.
module vram_wbuf #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_addr_i,
   input  logic [DATA_W-1:0] load_data_i,
   input  logic              drain_i,
   input  logic [ADDR_W-1:0] cmp_addr_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic              hit_o
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] data_q,  data_d;

   // Next-state: a load wins over a same-cycle drain, since the drained entry is already on the RAM bus.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         addr_d  = load_addr_i;
         data_d  = load_data_i;
      end else if (drain_i) begin
         valid_d = 1'b0;
      end
   end

   // Entry registers; reset discards any pending write.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;
   // Forwarding match for CPU reads that target the buffered address.
   assign hit_o   = valid_q && (addr_q == cmp_addr_i);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch (absolute priority), write-buffer drain, then CPU read.
// Latency: video 1 cycle fixed; CPU write/forwarded read ack +1, CPU read ack +2 after issue.
// Backpressure: video never stalls; CPU is held via req/ack until a slot or buffer entry frees.
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W
) (
   input  logic              clk_pixel,
   input  logic              reset,
   input  logic              vid_rd,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   arb_state_e        state_q, state_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic              vid_pend_q, vid_pend_d;
   logic [DATA_W-1:0] vid_hold_q, vid_hold_d;

   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              wb_hit;
   logic              wb_load;
   logic              wb_drain;
   logic              rd_issue;

   // The buffer drains in every slot the video port leaves free.
   assign wb_drain = wb_valid & ~vid_rd;

   vram_wbuf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wbuf (
      .clk_i       (clk_pixel),
      .reset_i     (reset),
      .load_i      (wb_load),
      .load_addr_i (cpu_addr),
      .load_data_i (cpu_wdata),
      .drain_i     (wb_drain),
      .cmp_addr_i  (cpu_addr),
      .valid_o     (wb_valid),
      .addr_o      (wb_addr),
      .data_o      (wb_data),
      .hit_o       (wb_hit)
   );

   // CPU sequencer: accept writes into the buffer, forward buffered reads, else issue reads in a free slot.
   always_comb begin
      state_d     = state_q;
      cpu_rdata_d = cpu_rdata_q;
      wb_load     = 1'b0;
      rd_issue    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cpu_req) begin
               if (cpu_we) begin
                  // A same-cycle drain frees the entry in time for this load.
                  if (!wb_valid || wb_drain) begin
                     wb_load = 1'b1;
                     state_d = S_ACK;
                  end
               end else if (wb_hit) begin
                  // Buffered data is newer than RAM; answer without touching the RAM.
                  cpu_rdata_d = wb_data;
                  state_d     = S_ACK;
               end else if (!vid_rd && !wb_valid) begin
                  // Slot is free only when neither video nor a drain claims it.
                  rd_issue = 1'b1;
                  state_d  = S_RDATA;
               end
            end
         end
         S_RDATA: begin
            // Synchronous RAM returns the byte addressed last cycle, whoever owns the slot now.
            cpu_rdata_d = ram_rdata;
            state_d     = S_ACK;
         end
         S_ACK: begin
            // Request line is still high from the finished access; it is not a new request.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Ack pulse is registered so the CPU sees a clean one-cycle strobe in S_ACK.
   assign cpu_ack_d = (state_d == S_ACK);

   // Video return path: live RAM data on the cycle after a fetch, held copy otherwise.
   always_comb begin
      vid_pend_d = vid_rd;
      vid_hold_d = vid_pend_q ? ram_rdata : vid_hold_q;
   end

   // Sequencer and video-return registers; reset drops any in-flight read without an ack.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         state_q     <= IDLE;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         vid_pend_q  <= 1'b0;
         vid_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         vid_pend_q  <= vid_pend_d;
         vid_hold_q  <= vid_hold_d;
      end
   end

   // RAM slot mux in priority order: video read, buffer drain, CPU read.
   always_comb begin
      ram_addr  = vid_addr;
      ram_we    = 1'b0;
      ram_wdata = wb_data;
      if (vid_rd) begin
         ram_addr = vid_addr;
      end else if (wb_valid) begin
         // Write enable is cut in the reset cycle so a discarded entry never reaches RAM.
         ram_addr = wb_addr;
         ram_we   = ~reset;
      end else if (rd_issue) begin
         ram_addr = cpu_addr;
      end
   end

   assign vid_data  = vid_pend_q ? ram_rdata : vid_hold_q;
   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ack   = cpu_ack_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;

   logic          clk_pixel = 1'b0;
   logic          reset;
   logic          vid_rd;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_data;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .vid_rd    (vid_rd),
      .vid_addr  (vid_addr),
      .vid_data  (vid_data),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 clk_pixel = ~clk_pixel;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   int we_cnt = 0;
   logic mem_init;
   bit   cpu_done;

   // Power-on RAM image: video region F6xx holds low byte + 0x41, 0x2000 holds 0x99.
   function automatic logic [7:0] init_byte(input logic [15:0] a);
      if (a[15:8] == 8'hF6) return a[7:0] + 8'h41;
      if (a == 16'h2000)    return 8'h99;
      return a[7:0] ^ a[15:8] ^ 8'hC3;
   endfunction

   // Synchronous single-port RAM behind the arbiter.
   logic [7:0] mem [0:65535];
   always @(posedge clk_pixel) begin
      if (mem_init) begin
         for (int i = 0; i < 65536; i++) mem[i] <= init_byte(16'(i));
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
         we_cnt        <= we_cnt + 1;
      end
      ram_rdata <= mem[ram_addr];
      cyc       <= cyc + 1;
   end

   // Reference model: CPU sees its own writes in program order.
   logic [7:0] shadow [logic [15:0]];
   function automatic logic [7:0] shadow_rd(input logic [15:0] a);
      if (shadow.exists(a)) return shadow[a];
      return init_byte(a);
   endfunction

   typedef struct {
      bit         is_rd;
      logic [7:0] d;
      int         t0;
      int         lat;
   } cpu_exp_t;

   cpu_exp_t   cpu_q[$];
   logic [7:0] vid_q[$];

   task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Monitor: video return data/hold, slot ownership and CPU completions.
   initial begin : monitor
      bit         prev_vid = 1'b0;
      logic [7:0] last_vid = 8'h00;
      cpu_exp_t   r;
      logic [7:0] e;
      forever begin
         @(negedge clk_pixel);
         if (vid_rd) begin
            chk("vid_slot_no_we", ram_we == 1'b0, ram_we, 0);
            chk("vid_slot_addr", ram_addr == vid_addr, ram_addr, vid_addr);
         end
         if (reset) chk("reset_we", ram_we == 1'b0, ram_we, 0);
         if (prev_vid) begin
            if (vid_q.size() == 0) chk("vid_underflow", 1'b0, 1, 0);
            else begin
               e = vid_q.pop_front();
               chk("vid_data", vid_data == e, vid_data, e);
               last_vid = e;
            end
         end else begin
            chk("vid_hold", vid_data == last_vid, vid_data, last_vid);
         end
         prev_vid = vid_rd;
         if (reset) begin
            prev_vid = 1'b0;
            last_vid = 8'h00;
         end
         if (cpu_ack) begin
            if (cpu_q.size() == 0) chk("stray_ack", 1'b0, 1, 0);
            else begin
               r = cpu_q.pop_front();
               if (r.is_rd) chk("cpu_rdata", cpu_rdata == r.d, cpu_rdata, r.d);
               if (r.lat >= 0) chk("ack_latency", (cyc - r.t0) == r.lat, cyc - r.t0, r.lat);
               else            chk("ack_bound", (cyc - r.t0) <= 5, cyc - r.t0, 5);
            end
         end
      end
   end

   // Drive one video cycle (entered and left at posedge+1).
   task automatic vid_step(input bit on, input logic [15:0] a, input logic [7:0] exp);
      vid_rd   = on;
      vid_addr = a;
      if (on) vid_q.push_back(exp);
      @(posedge clk_pixel); #1;
   endtask

   // One CPU access; returns at posedge+1 of the cycle after the ack with req dropped.
   task automatic cpu_op(input bit we, input logic [15:0] a, input logic [7:0] d, input int lat);
      cpu_exp_t r;
      int n;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = d;
      r.is_rd = !we;
      r.d     = we ? 8'h00 : shadow_rd(a);
      r.t0    = cyc;
      r.lat   = lat;
      cpu_q.push_back(r);
      if (we) shadow[a] = d;
      n = 0;
      do begin
         @(negedge clk_pixel);
         n++;
      end while (!cpu_ack && n < 20);
      if (!cpu_ack) begin
         chk("ack_timeout", 1'b0, n, lat);
         void'(cpu_q.pop_back());
      end
      @(posedge clk_pixel); #1;
      cpu_req = 1'b0;
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 60000", cyc);
      $fatal(1);
   end

   initial begin : stim
      int we0;
      logic [15:0] a;
      reset = 1'b1; mem_init = 1'b1; cpu_done = 1'b0;
      vid_rd = 1'b0; vid_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      @(posedge clk_pixel); #1;
      mem_init = 1'b0;
      repeat (2) @(posedge clk_pixel);
      #1 reset = 1'b0;

      // Idle after reset: outputs at reset values, no writes.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_pixel);
         chk("idle_ram_we", ram_we == 1'b0, ram_we, 0);
         chk("idle_cpu_ack", cpu_ack == 1'b0, cpu_ack, 0);
         if (i == 0) begin
            chk("rst_cpu_rdata", cpu_rdata == 8'h00, cpu_rdata, 0);
            chk("rst_vid_data", vid_data == 8'h00, vid_data, 0);
         end
      end
      @(posedge clk_pixel); #1;

      // Video read of 0xF600, then held.
      vid_step(1'b1, 16'hF600, 8'h41);
      repeat (3) vid_step(1'b0, 16'h0000, 8'h00);

      // Write under three video cycles; video to the same address sees the old byte.
      we0 = we_cnt;
      fork
         cpu_op(1'b1, 16'h1234, 8'h5A, 1);
         begin
            vid_step(1'b1, 16'h1234, init_byte(16'h1234));
            vid_step(1'b1, 16'hF601, init_byte(16'hF601));
            vid_step(1'b1, 16'hF602, init_byte(16'hF602));
            vid_step(1'b0, 16'h0000, 8'h00);
         end
      join
      chk("drain_count", (we_cnt - we0) == 1, we_cnt - we0, 1);
      chk("drain_data", mem[16'h1234] == 8'h5A, mem[16'h1234], 8'h5A);
      vid_step(1'b1, 16'h1234, 8'h5A);
      vid_step(1'b0, 16'h0000, 8'h00);

      // Write then read of the same address while video blocks the drain: forwarded.
      fork
         begin
            cpu_op(1'b1, 16'h0100, 8'h77, 1);
            cpu_op(1'b0, 16'h0100, 8'h00, 1);
         end
         begin
            for (int i = 0; i < 4; i++) vid_step(1'b1, 16'hF610 + 16'(i), init_byte(16'hF610 + 16'(i)));
            vid_step(1'b0, 16'h0000, 8'h00);
         end
      join

      // Read of 0x2000 colliding with a video fetch: issue slips a cycle.
      fork
         cpu_op(1'b0, 16'h2000, 8'h00, 3);
         begin
            vid_step(1'b1, 16'hF620, init_byte(16'hF620));
            repeat (4) vid_step(1'b0, 16'h0000, 8'h00);
         end
      join

      // Reset with a buffered write and a waiting read.
      we0 = we_cnt;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 8'hEE;
      cpu_q.push_back('{is_rd: 1'b0, d: 8'h00, t0: cyc, lat: 1});
      vid_step(1'b1, 16'hF630, init_byte(16'hF630));
      vid_step(1'b1, 16'hF631, init_byte(16'hF631));
      cpu_we = 1'b0; cpu_addr = 16'h3100;
      vid_step(1'b1, 16'hF632, init_byte(16'hF632));
      vid_step(1'b1, 16'hF633, init_byte(16'hF633));
      vid_rd = 1'b0; reset = 1'b1; cpu_req = 1'b0;
      @(negedge clk_pixel);
      chk("reset_cycle_we", ram_we == 1'b0, ram_we, 0);
      @(posedge clk_pixel); #1;
      reset = 1'b0;
      repeat (8) @(posedge clk_pixel);
      #1;
      chk("reset_no_drain", we_cnt == we0, we_cnt - we0, 0);
      chk("reset_ram_kept", mem[16'h3000] == init_byte(16'h3000), mem[16'h3000], init_byte(16'h3000));
      chk("reset_rdata", cpu_rdata == 8'h00, cpu_rdata, 0);

      // Randomized traffic: video at most every other cycle, CPU on a small address window.
      fork
         begin
            bit last = 1'b0;
            while (!cpu_done) begin
               if (!last && $urandom_range(1, 0) == 1) begin
                  a = 16'hF600 | 16'($urandom_range(255, 0));
                  vid_step(1'b1, a, init_byte(a));
                  last = 1'b1;
               end else begin
                  vid_step(1'b0, 16'h0000, 8'h00);
                  last = 1'b0;
               end
            end
         end
         begin
            logic [15:0] ca;
            for (int k = 0; k < 250; k++) begin
               repeat ($urandom_range(2, 0)) begin
                  @(posedge clk_pixel); #1;
               end
               ca = 16'h1230 + 16'($urandom_range(7, 0));
               cpu_op(1'($urandom_range(1, 0)), ca, 8'($urandom), -1);
            end
            cpu_done = 1'b1;
         end
      join
      repeat (4) vid_step(1'b0, 16'h0000, 8'h00);

      chk("vid_queue_empty", vid_q.size() == 0, vid_q.size(), 0);
      chk("cpu_queue_empty", cpu_q.size() == 0, cpu_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
